// File: rtl/nor_logic_unit_if.sv
// Handshake and data bundle for the NOR logic unit.
// The producer/consumer side uses the master modport; the unit itself uses slave.
interface nor_logic_unit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic             acc_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic [WIDTH-1:0] acc_q;

    modport master (
        output in_valid, op, acc_mode, a, b, out_ready,
        input  in_ready, out_valid, y, zero, acc_q
    );

    modport slave (
        input  in_valid, op, acc_mode, a, b, out_ready,
        output in_ready, out_valid, y, zero, acc_q
    );
endinterface

// File: rtl/nor_logic_unit.sv
// Registered bitwise logic stage: eight functions built only from 2-input NOR
// gates, one-deep output register with valid/ready backpressure, and an
// accumulator that can stand in for operand A and capture the result.
module nor_logic_unit #(
    parameter int          WIDTH    = 8,
    parameter int unsigned ACC_INIT = 0
) (
    input logic             clk,
    input logic             rst,
    nor_logic_unit_if.slave bus
);
    localparam logic [WIDTH-1:0] ACC_INIT_W = WIDTH'(ACC_INIT);

    logic [WIDTH-1:0] r_y;
    logic             r_zero;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_acc;

    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_a_sel;
    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_or;
    logic [WIDTH-1:0] w_not_a;
    logic [WIDTH-1:0] w_nand;
    logic [WIDTH-1:0] w_xor;
    logic [WIDTH-1:0] w_xnor;
    logic [WIDTH-1:0] w_nor;
    logic [WIDTH-1:0] w_pass;
    logic [WIDTH-1:0] w_y_next;

    function automatic logic nor2(input logic x, input logic z);
        return ~(x | z);
    endfunction

    // The output slot frees up either when empty or when it drains this cycle.
    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_a_sel    = bus.acc_mode ? r_acc : bus.a;

    // Per-bit NOR network producing every candidate function in parallel.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic w_na;
        logic w_nb;
        logic w_nab;
        logic w_n2;
        logic w_n3;
        logic w_xn;

        assign w_na  = nor2(w_a_sel[gi], w_a_sel[gi]);
        assign w_nb  = nor2(bus.b[gi], bus.b[gi]);
        assign w_nab = nor2(w_a_sel[gi], bus.b[gi]);
        // w_n2 = ~A & B, w_n3 = A & ~B; NOR of the two is XNOR.
        assign w_n2  = nor2(w_a_sel[gi], w_nab);
        assign w_n3  = nor2(bus.b[gi], w_nab);
        assign w_xn  = nor2(w_n2, w_n3);

        assign w_and[gi]   = nor2(w_na, w_nb);
        assign w_or[gi]    = nor2(w_nab, w_nab);
        assign w_not_a[gi] = w_na;
        assign w_nand[gi]  = nor2(w_and[gi], w_and[gi]);
        assign w_xnor[gi]  = w_xn;
        assign w_xor[gi]   = nor2(w_xn, w_xn);
        assign w_nor[gi]   = w_nab;
        assign w_pass[gi]  = nor2(w_na, w_na);
    end

    // Function select.
    always_comb begin
        w_y_next = '0;
        case (bus.op)
            3'd0:    w_y_next = w_and;
            3'd1:    w_y_next = w_or;
            3'd2:    w_y_next = w_not_a;
            3'd3:    w_y_next = w_nand;
            3'd4:    w_y_next = w_xor;
            3'd5:    w_y_next = w_xnor;
            3'd6:    w_y_next = w_nor;
            3'd7:    w_y_next = w_pass;
            default: w_y_next = '0;
        endcase
    end

    // Output register, zero flag and accumulator; reset wins over an accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_zero      <= 1'b0;
            r_acc       <= ACC_INIT_W;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_y         <= w_y_next;
            r_zero      <= (w_y_next == '0);
            if (bus.acc_mode) begin
                r_acc <= w_y_next;
            end
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.y         = r_y;
    assign bus.zero      = r_zero;
    assign bus.acc_q     = r_acc;
endmodule

// File: tb/tb_nor_logic_unit.sv
// Bench for nor_logic_unit: directed table and corner sequences on an 8-bit
// instance, plus randomized runs on 1-bit and 32-bit instances.
module tb_nor_logic_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    nor_logic_unit_if #(.WIDTH(8)) bus8 ();
    nor_logic_unit #(.WIDTH(8), .ACC_INIT(0)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] width_mask(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // Reference: the eight functions written with ordinary operators.
    function automatic logic [31:0] ref_f(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input int w);
        logic [31:0] r;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = ~a;
            3'd3:    r = ~(a & b);
            3'd4:    r = a ^ b;
            3'd5:    r = ~(a ^ b);
            3'd6:    r = ~(a | b);
            default: r = a;
        endcase
        return r & width_mask(w);
    endfunction

    typedef struct {
        logic [2:0] op;
        logic       acc_mode;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_y;
        logic [7:0] exp_acc;
    } vec_t;

    // Randomized width sweep: each instance has its own reset and model.
    for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
        localparam int          W    = (gi == 0) ? 1 : 32;
        localparam int unsigned INIT = (gi == 0) ? 1 : 32'hDEAD_BEEF;

        logic s_rst;
        logic done = 1'b0;

        nor_logic_unit_if #(.WIDTH(W)) sbus ();
        nor_logic_unit #(.WIDTH(W), .ACC_INIT(INIT)) u_dut (
            .clk (clk),
            .rst (s_rst),
            .bus (sbus)
        );

        initial begin
            logic [31:0] m_y;
            logic [31:0] m_acc;
            logic        m_valid;
            logic        m_zero;
            logic [31:0] a_v;
            logic [31:0] b_v;
            logic [31:0] yn;
            logic [2:0]  op_v;
            logic        am_v;
            logic        iv_v;
            logic        or_v;
            logic        acc_now;
            int          n_acc;
            int          cyc;

            s_rst          = 1'b1;
            sbus.in_valid  = 1'b0;
            sbus.out_ready = 1'b0;
            sbus.op        = 3'd0;
            sbus.acc_mode  = 1'b0;
            sbus.a         = '0;
            sbus.b         = '0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            s_rst   = 1'b0;
            m_y     = 32'd0;
            m_zero  = 1'b0;
            m_valid = 1'b0;
            m_acc   = INIT & width_mask(W);
            n_acc   = 0;
            cyc     = 0;

            while (n_acc < 1000 && cyc < 8000) begin
                check($sformatf("w%0d_out_valid", W), 32'(sbus.out_valid), 32'(m_valid));
                check($sformatf("w%0d_y", W), 32'(sbus.y), m_y);
                check($sformatf("w%0d_zero", W), 32'(sbus.zero), 32'(m_zero));
                check($sformatf("w%0d_acc_q", W), 32'(sbus.acc_q), m_acc);

                a_v  = $urandom() & width_mask(W);
                b_v  = $urandom() & width_mask(W);
                op_v = 3'($urandom_range(0, 7));
                am_v = 1'($urandom_range(0, 1));
                iv_v = ($urandom_range(0, 3) != 0);
                or_v = ($urandom_range(0, 2) != 0);
                sbus.a         = a_v[W-1:0];
                sbus.b         = b_v[W-1:0];
                sbus.op        = op_v;
                sbus.acc_mode  = am_v;
                sbus.in_valid  = iv_v;
                sbus.out_ready = or_v;
                #1;
                check($sformatf("w%0d_in_ready", W), 32'(sbus.in_ready), 32'(!m_valid || or_v));
                acc_now = iv_v && (!m_valid || or_v);

                @(posedge clk);
                cyc++;
                if (acc_now) begin
                    yn      = ref_f(op_v, am_v ? m_acc : a_v, b_v, W);
                    m_y     = yn;
                    m_zero  = (yn == 32'd0);
                    m_valid = 1'b1;
                    if (am_v) m_acc = yn;
                    n_acc++;
                    $display("w%0d txn %0d op=%0d acc_mode=%0d a=%0h b=%0h -> y=%0h", W, n_acc, op_v, am_v, a_v, b_v, yn);
                end else if (or_v) begin
                    m_valid = 1'b0;
                end
                @(negedge clk);
            end
            check($sformatf("w%0d_transfer_count", W), 32'(n_acc), 32'd1000);
            sbus.in_valid = 1'b0;
            done = 1'b1;
        end
    end

    // Directed scenarios on the 8-bit instance.
    initial begin
        vec_t        vecs[12];
        logic [7:0]  m_acc;
        logic [7:0]  a_v;
        logic [7:0]  b_v;
        logic [7:0]  exp_y;
        logic [2:0]  op_v;
        logic        am_v;
        int          wait_cyc;

        // op sweep on 0xCC/0xAA, then the accumulator chain
        vecs[0]  = '{3'd0, 1'b0, 8'hCC, 8'hAA, 8'h88, 8'h00};
        vecs[1]  = '{3'd1, 1'b0, 8'hCC, 8'hAA, 8'hEE, 8'h00};
        vecs[2]  = '{3'd2, 1'b0, 8'hCC, 8'hAA, 8'h33, 8'h00};
        vecs[3]  = '{3'd3, 1'b0, 8'hCC, 8'hAA, 8'h77, 8'h00};
        vecs[4]  = '{3'd4, 1'b0, 8'hCC, 8'hAA, 8'h66, 8'h00};
        vecs[5]  = '{3'd5, 1'b0, 8'hCC, 8'hAA, 8'h99, 8'h00};
        vecs[6]  = '{3'd6, 1'b0, 8'hCC, 8'hAA, 8'h11, 8'h00};
        vecs[7]  = '{3'd7, 1'b0, 8'hCC, 8'hAA, 8'hCC, 8'h00};
        vecs[8]  = '{3'd1, 1'b1, 8'h00, 8'h0F, 8'h0F, 8'h0F};
        vecs[9]  = '{3'd4, 1'b1, 8'h00, 8'hFF, 8'hF0, 8'hF0};
        vecs[10] = '{3'd2, 1'b1, 8'h00, 8'h00, 8'h0F, 8'h0F};
        vecs[11] = '{3'd1, 1'b0, 8'h01, 8'h02, 8'h03, 8'h0F};

        rst            = 1'b1;
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b0;
        bus8.op        = 3'd0;
        bus8.acc_mode  = 1'b0;
        bus8.a         = 8'h00;
        bus8.b         = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_valid", 32'(bus8.out_valid), 32'd0);
        check("reset_y", 32'(bus8.y), 32'd0);
        check("reset_zero", 32'(bus8.zero), 32'd0);
        check("reset_acc_q", 32'(bus8.acc_q), 32'd0);
        check("reset_in_ready", 32'(bus8.in_ready), 32'd1);

        // Table: streamed back-to-back with out_ready held high.
        for (int i = 0; i < 12; i++) begin
            bus8.in_valid  = 1'b1;
            bus8.out_ready = 1'b1;
            bus8.op        = vecs[i].op;
            bus8.acc_mode  = vecs[i].acc_mode;
            bus8.a         = vecs[i].a;
            bus8.b         = vecs[i].b;
            #1;
            check($sformatf("vec%0d_in_ready", i), 32'(bus8.in_ready), 32'd1);
            @(posedge clk);
            @(negedge clk);
            $display("vec%0d op=%0d acc_mode=%0d a=%02h b=%02h -> y=%02h acc_q=%02h", i,
                     vecs[i].op, vecs[i].acc_mode, vecs[i].a, vecs[i].b, bus8.y, bus8.acc_q);
            check($sformatf("vec%0d_out_valid", i), 32'(bus8.out_valid), 32'd1);
            check($sformatf("vec%0d_y", i), 32'(bus8.y), 32'(vecs[i].exp_y));
            check($sformatf("vec%0d_zero", i), 32'(bus8.zero), 32'd0);
            check($sformatf("vec%0d_acc_q", i), 32'(bus8.acc_q), 32'(vecs[i].exp_acc));
        end
        m_acc = 8'h0F;

        // Drain with nothing new offered.
        bus8.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("drain_out_valid", 32'(bus8.out_valid), 32'd0);

        // Zero flag and hold under backpressure.
        bus8.in_valid  = 1'b1;
        bus8.out_ready = 1'b0;
        bus8.op        = 3'd0;
        bus8.acc_mode  = 1'b0;
        bus8.a         = 8'hF0;
        bus8.b         = 8'h0F;
        #1;
        check("hold_first_in_ready", 32'(bus8.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        $display("hold op=0 a=f0 b=0f -> y=%02h zero=%0d", bus8.y, bus8.zero);
        bus8.op = 3'd1;
        bus8.a  = 8'h55;
        bus8.b  = 8'h22;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("hold%0d_out_valid", c), 32'(bus8.out_valid), 32'd1);
            check($sformatf("hold%0d_y", c), 32'(bus8.y), 32'h00);
            check($sformatf("hold%0d_zero", c), 32'(bus8.zero), 32'd1);
            check($sformatf("hold%0d_in_ready", c), 32'(bus8.in_ready), 32'd0);
            check($sformatf("hold%0d_acc_q", c), 32'(bus8.acc_q), 32'(m_acc));
            @(posedge clk);
            @(negedge clk);
        end
        bus8.out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(bus8.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        $display("release op=1 a=55 b=22 -> y=%02h", bus8.y);
        check("release_y", 32'(bus8.y), 32'h77);
        check("release_zero", 32'(bus8.zero), 32'd0);
        check("release_out_valid", 32'(bus8.out_valid), 32'd1);

        // Full throughput: 16 random accepts with in_valid and out_ready high.
        for (int i = 0; i < 16; i++) begin
            a_v  = 8'($urandom());
            b_v  = 8'($urandom());
            op_v = 3'($urandom_range(0, 7));
            am_v = 1'($urandom_range(0, 1));
            bus8.in_valid  = 1'b1;
            bus8.out_ready = 1'b1;
            bus8.op        = op_v;
            bus8.acc_mode  = am_v;
            bus8.a         = a_v;
            bus8.b         = b_v;
            #1;
            check($sformatf("stream%0d_in_ready", i), 32'(bus8.in_ready), 32'd1);
            exp_y = 8'(ref_f(op_v, am_v ? 32'(m_acc) : 32'(a_v), 32'(b_v), 8));
            if (am_v) m_acc = exp_y;
            @(posedge clk);
            @(negedge clk);
            $display("stream%0d op=%0d acc_mode=%0d a=%02h b=%02h -> y=%02h", i, op_v, am_v, a_v, b_v, bus8.y);
            check($sformatf("stream%0d_out_valid", i), 32'(bus8.out_valid), 32'd1);
            check($sformatf("stream%0d_y", i), 32'(bus8.y), 32'(exp_y));
            check($sformatf("stream%0d_zero", i), 32'(bus8.zero), 32'(exp_y == 8'h00));
            check($sformatf("stream%0d_acc_q", i), 32'(bus8.acc_q), 32'(m_acc));
        end

        // Load 0x5A into the accumulator, then hold the result.
        bus8.acc_mode = 1'b1;
        bus8.op       = 3'd0;
        bus8.b        = 8'h00;
        @(posedge clk);
        @(negedge clk);
        bus8.op = 3'd1;
        bus8.b  = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        bus8.out_ready = 1'b0;
        bus8.op        = 3'd7;
        #1;
        check("prerst_acc_q", 32'(bus8.acc_q), 32'h5A);
        check("prerst_out_valid", 32'(bus8.out_valid), 32'd1);
        check("prerst_in_ready", 32'(bus8.in_ready), 32'd0);

        // Reset while a result is held and a new operand is offered.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst           = 1'b0;
        bus8.in_valid = 1'b0;
        #1;
        $display("midreset -> out_valid=%0d y=%02h acc_q=%02h", bus8.out_valid, bus8.y, bus8.acc_q);
        check("midrst_out_valid", 32'(bus8.out_valid), 32'd0);
        check("midrst_y", 32'(bus8.y), 32'h00);
        check("midrst_zero", 32'(bus8.zero), 32'd0);
        check("midrst_acc_q", 32'(bus8.acc_q), 32'h00);
        check("midrst_in_ready", 32'(bus8.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("postrst_out_valid", 32'(bus8.out_valid), 32'd0);
        check("postrst_acc_q", 32'(bus8.acc_q), 32'h00);

        // Wait for both randomized sweeps, with a bound.
        wait_cyc = 0;
        while (!(g_sweep[0].done && g_sweep[1].done) && wait_cyc < 20000) begin
            @(posedge clk);
            wait_cyc++;
        end
        check("sweeps_finished", 32'(g_sweep[0].done && g_sweep[1].done), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
